// File: rtl/instr_encode_writer.sv
// Packs decoded RV32 instruction fields into a 32-bit word and writes it
// sequentially into a program buffer, one word per IDLE/ENCODE/WRITE pass.
module instr_encode_writer #(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    WRITE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_U = 3'b011,
    FMT_J = 3'b100,
    FMT_R = 3'b101
  } fmt_t;

  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_t      state_q, state_d;
  logic        accept;
  logic        legal;
  logic [31:0] word;

  logic [2:0]  fmt_q;
  logic [6:0]  opcode_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [2:0]  funct3_q;
  logic [6:0]  funct7_q;
  logic [31:0] imm_q;

  assign full   = (count == FULL_COUNT);
  assign accept = in_valid && in_ready && !clear;

  // NOTE: the captured field bundle is pure datapath; it is only consumed in
  // ENCODE, which is unreachable without a fresh capture, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      fmt_q    <= fmt;
      opcode_q <= opcode;
      rd_q     <= rd;
      rs1_q    <= rs1;
      rs2_q    <= rs2;
      funct3_q <= funct3;
      funct7_q <= funct7;
      imm_q    <= imm;
    end
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    legal = 1'b1;
    word  = 32'h0;
    case (fmt_q)
      FMT_I: word = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
      FMT_S: word = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
      FMT_B: word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                     imm_q[4:1], imm_q[11], opcode_q};
      FMT_U: word = {imm_q[31:12], rd_q, opcode_q};
      FMT_J: word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12],
                     rd_q, opcode_q};
      FMT_R: word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == IDLE) && !full;
    mem_we   = (state_q == WRITE);
    err      = (state_q == ENCODE) && !legal;
    case (state_q)
      IDLE:    if (accept) state_d = ENCODE;
      ENCODE:  state_d = legal ? WRITE : IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Clear drops whatever is in flight; an ENCODE never reaches WRITE.
    if (clear) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count     <= '0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        count <= '0;
      end else if (state_q == WRITE) begin
        count <= count + 1'b1;
      end
      if (state_q == ENCODE && legal && !clear) begin
        mem_addr  <= BASE_ADDR + (32'(count) << 2);
        mem_wdata <= word;
      end
    end
  end

endmodule
